stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Sequencing controller for the 4-digit BCD counter; together they form a start/stop/lap stopwatch.
- Generates the counter's enable ticks from a prescaler and issues clear pulses.
- Runs a run/pause/lap/overflow FSM, drives a 4-digit display bus (live or lap-frozen value), and saturates at 9999 instead of wrapping.
- At top level the counter's rst input is driven by rst OR cnt_clr; its en input is driven by cnt_en.

Parameters:
- TICK_DIV, 100000, clk cycles per counter increment (>= 2).
- PS_W, 17, prescaler width; must satisfy 2^PS_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_ss  input  1  start/stop request, level, already synchronised and debounced.
- btn_lr  input  1  lap/reset request, level, already synchronised and debounced.
- cnt_bcd1  input  4  counter digit 0 (units).
- cnt_bcd2  input  4  counter digit 1.
- cnt_bcd3  input  4  counter digit 2.
- cnt_bcd4  input  4  counter digit 3 (thousands).
- cnt_en  output  1  counter enable, one-cycle pulse per tick.
- cnt_clr  output  1  counter clear, one-cycle pulse.
- disp_bcd1  output  4  display digit 0.
- disp_bcd2  output  4  display digit 1.
- disp_bcd3  output  4  display digit 2.
- disp_bcd4  output  4  display digit 3.
- state  output  3  FSM state: IDLE=0, RUN=1, LAP=2, PAUSED=3, OVF=4.
- ovf  output  1  high while in OVF.

Behaviour:
- Reset is asynchronous and active-high, on clk. While rst is high, every output and register is 0: state=IDLE, cnt_en=0, cnt_clr=0, disp=0000, ovf=0, prescaler=0, lap latch=0, edge-detect history=0.
- Buttons are rising-edge detected using a one-cycle history register.
  - ss_evt = btn_ss & ~btn_ss_d; lr_evt is formed the same way from btn_lr.
  - A button held high produces exactly one event.
  - An event sampled at edge N takes effect in state/outputs at edge N (registered FSM, one edge after the input rises).
- Prescaler:
  - Increments each cycle in RUN or LAP.
  - Holds its value in PAUSED.
  - Is forced to 0 in IDLE and OVF.
  - Terminal count is TICK_DIV-1; on reaching it the prescaler wraps to 0 and a tick fires.
- Tick handling, evaluated in RUN/LAP:
  - If cnt_bcd4..1 != 9999: cnt_en=1 for exactly the next cycle.
  - If cnt_bcd4..1 == 9999: cnt_en stays 0 and the FSM moves to OVF. The counter therefore never wraps.
- FSM transitions (priority order within each state: overflow tick, then ss_evt, then lr_evt; lr_evt is ignored in a cycle where ss_evt is also present):
  - IDLE: ss_evt -> RUN. lr_evt -> pulse cnt_clr, stay IDLE.
  - RUN: overflow tick -> OVF. ss_evt -> PAUSED. lr_evt -> LAP and latch cnt_bcd4..1 into the lap register.
  - LAP: overflow tick -> OVF. ss_evt -> PAUSED. lr_evt -> RUN (lap released).
  - PAUSED: ss_evt -> RUN, with the prescaler resuming from its held value. lr_evt -> pulse cnt_clr and go to IDLE.
  - OVF: ss_evt is ignored. lr_evt -> pulse cnt_clr and go to IDLE.
- cnt_clr is a one-cycle registered pulse, asserted on the same edge as the transition that causes it. The counter reads 0000 on the following cycle.
- A tick and ss_evt in the same cycle in RUN: the tick's cnt_en is still issued, and the FSM goes to PAUSED.
- Display (registered, one cycle behind the counter digits):
  - LAP: disp = lap register.
  - All other states: disp = cnt_bcd4..1.
- ovf = (state == OVF).
- rst asserted mid-run aborts immediately into IDLE with all outputs at their reset values. rst does not pulse cnt_clr; the counter's own reset covers it.

Test Plan (bench uses TICK_DIV=4, with the real 4-digit counter wired as in the Overview):
1. Reset, then 1-cycle btn_ss pulse -> state=1. cnt_en pulses every 4 clk. After 40 clk, disp=0010.
2. RUN at 0012: btn_lr pulse -> state=2, disp frozen at 0012 while cnt_bcd keeps counting. Second btn_lr pulse -> state=1, disp live again.
3. btn_ss held high for 20 clk in RUN -> exactly one transition to PAUSED (state=3). Prescaler and counter hold. btn_ss pulse -> RUN, next cnt_en after the remaining prescaler cycles.
4. PAUSED at 0037: btn_lr pulse -> cnt_clr high for exactly 1 cycle, state=0, disp=0000 two cycles later.
5. Preload counter near 9999 (force) and run -> cnt_en is not issued at 9999, state=4, ovf=1, disp=9999 stable for 100 clk. btn_ss is ignored. btn_lr -> cnt_clr pulse, IDLE, 0000.
6. btn_ss and btn_lr rising in the same cycle in RUN -> state=3, no lap latch, no cnt_clr. rst asserted mid-RUN -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap sequencer for a 4-digit BCD counter.
// Prescaled count ticks, clear pulses, lap freeze and saturation at 9999.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int PS_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] cnt_bcd1,
    input  logic [3:0] cnt_bcd2,
    input  logic [3:0] cnt_bcd3,
    input  logic [3:0] cnt_bcd4,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [3:0] disp_bcd1,
    output logic [3:0] disp_bcd2,
    output logic [3:0] disp_bcd3,
    output logic [3:0] disp_bcd4,
    output logic [2:0] state,
    output logic       ovf
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_LAP    = 3'd2,
        S_PAUSED = 3'd3,
        S_OVF    = 3'd4
    } state_t;

    localparam logic [PS_W-1:0] PS_TC = PS_W'(TICK_DIV - 1);

    state_t          cur;
    state_t          nxt;
    logic [PS_W-1:0] ps;
    logic [PS_W-1:0] ps_nxt;
    logic            ss_d;
    logic            lr_d;
    logic            ss_evt;
    logic            lr_evt;
    logic            running;
    logic            tick;
    logic            at_max;
    logic            ovf_tick;
    logic            en_nxt;
    logic            clr_nxt;
    logic            lap_load;
    logic [15:0]     cnt_val;
    logic [15:0]     lap;
    logic [15:0]     disp;

    assign cnt_val  = {cnt_bcd4, cnt_bcd3, cnt_bcd2, cnt_bcd1};
    assign ss_evt   = btn_ss & ~ss_d;
    assign lr_evt   = btn_lr & ~lr_d;
    assign running  = (cur == S_RUN) || (cur == S_LAP);
    assign tick     = running && (ps == PS_TC);
    assign at_max   = (cnt_val == 16'h9999);
    assign ovf_tick = tick & at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE: begin
                if (ss_evt) nxt = S_RUN;
            end
            S_RUN: begin
                if (ovf_tick)    nxt = S_OVF;
                else if (ss_evt) nxt = S_PAUSED;
                else if (lr_evt) nxt = S_LAP;
            end
            S_LAP: begin
                if (ovf_tick)    nxt = S_OVF;
                else if (ss_evt) nxt = S_PAUSED;
                else if (lr_evt) nxt = S_RUN;
            end
            S_PAUSED: begin
                if (ss_evt)      nxt = S_RUN;
                else if (lr_evt) nxt = S_IDLE;
            end
            S_OVF: begin
                if (lr_evt && !ss_evt) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // A clear accompanies every lap/reset press outside RUN and LAP.
    always_comb begin
        en_nxt   = tick & ~at_max;
        clr_nxt  = 1'b0;
        lap_load = 1'b0;
        ps_nxt   = '0;
        unique case (cur)
            S_IDLE, S_PAUSED, S_OVF: begin
                clr_nxt = lr_evt & ~ss_evt;
            end
            S_RUN: begin
                lap_load = lr_evt & ~ss_evt & ~ovf_tick;
            end
            default: ;
        endcase
        if (running) begin
            ps_nxt = tick ? '0 : ps + 1'b1;
        end else if (cur == S_PAUSED) begin
            ps_nxt = ps;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_d    <= 1'b0;
            lr_d    <= 1'b0;
            ps      <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            lap     <= '0;
            disp    <= '0;
        end else begin
            ss_d    <= btn_ss;
            lr_d    <= btn_lr;
            ps      <= ps_nxt;
            cnt_en  <= en_nxt;
            cnt_clr <= clr_nxt;
            if (lap_load) lap <= cnt_val;
            disp    <= (cur == S_LAP) ? lap : cnt_val;
        end
    end

    assign disp_bcd1 = disp[3:0];
    assign disp_bcd2 = disp[7:4];
    assign disp_bcd3 = disp[11:8];
    assign disp_bcd4 = disp[15:12];
    assign state     = cur;
    assign ovf       = (cur == S_OVF);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a BCD counter fixture and a decimal reference model.
// Directed plan steps followed by a randomized button/preload/reset phase.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic [3:0] cnt_bcd1, cnt_bcd2, cnt_bcd3, cnt_bcd4;
    logic       cnt_en, cnt_clr, ovf;
    logic [3:0] disp_bcd1, disp_bcd2, disp_bcd3, disp_bcd4;
    logic [2:0] state;

    logic        ld = 1'b0;
    int          ld_val = 0;
    logic [15:0] cnt;

    int n_chk = 0;
    int n_err = 0;

    // model state (plain decimal numbers)
    int m_st, m_ps, m_cnt, m_lap, m_disp;
    bit m_pss, m_plr, m_en, m_clr;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD), .PS_W(3)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .cnt_bcd1(cnt_bcd1), .cnt_bcd2(cnt_bcd2),
        .cnt_bcd3(cnt_bcd3), .cnt_bcd4(cnt_bcd4),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .disp_bcd1(disp_bcd1), .disp_bcd2(disp_bcd2),
        .disp_bcd3(disp_bcd3), .disp_bcd4(disp_bcd4),
        .state(state), .ovf(ovf)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // 4-digit BCD counter fixture, cleared by rst or cnt_clr, wraps like real hardware
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= to_bcd(ld_val);
        end else if (cnt_en) begin
            if (cnt[3:0] != 4'd9) cnt[3:0] <= cnt[3:0] + 4'd1;
            else begin
                cnt[3:0] <= 4'd0;
                if (cnt[7:4] != 4'd9) cnt[7:4] <= cnt[7:4] + 4'd1;
                else begin
                    cnt[7:4] <= 4'd0;
                    if (cnt[11:8] != 4'd9) cnt[11:8] <= cnt[11:8] + 4'd1;
                    else begin
                        cnt[11:8] <= 4'd0;
                        cnt[15:12] <= (cnt[15:12] == 4'd9) ? 4'd0 : cnt[15:12] + 4'd1;
                    end
                end
            end
        end
    end

    assign cnt_bcd1 = cnt[3:0];
    assign cnt_bcd2 = cnt[7:4];
    assign cnt_bcd3 = cnt[11:8];
    assign cnt_bcd4 = cnt[15:12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ps = 0; m_cnt = 0; m_lap = 0; m_disp = 0;
        m_pss = 0; m_plr = 0; m_en = 0; m_clr = 0;
    endtask

    // One clock edge of the stopwatch rules, using the inputs present before the edge.
    task automatic model_edge();
        bit ss = btn_ss && !m_pss;
        bit lr = btn_lr && !m_plr;
        bit run = (m_st == 1) || (m_st == 2);
        bit tk = run && (m_ps == TD - 1);
        bit full = (m_cnt == 9999);
        int nst = m_st;
        int nlap = m_lap;
        bit nclr = 0;
        int ncnt;
        case (m_st)
            0: if (ss) nst = 1; else if (lr) nclr = 1;
            1: if (tk && full) nst = 4; else if (ss) nst = 3;
               else if (lr) begin nst = 2; nlap = m_cnt; end
            2: if (tk && full) nst = 4; else if (ss) nst = 3; else if (lr) nst = 1;
            3: if (ss) nst = 1; else if (lr) begin nst = 0; nclr = 1; end
            default: if (lr && !ss) begin nst = 0; nclr = 1; end
        endcase
        if (m_clr) ncnt = 0;
        else if (ld) ncnt = ld_val;
        else if (m_en) ncnt = (m_cnt + 1) % 10000;
        else ncnt = m_cnt;
        m_disp = (m_st == 2) ? m_lap : m_cnt;
        m_ps = run ? (tk ? 0 : m_ps + 1) : (m_st == 3) ? m_ps : 0;
        m_en = tk && !full;
        m_clr = nclr;
        m_st = nst;
        m_lap = nlap;
        m_cnt = ncnt;
        m_pss = btn_ss;
        m_plr = btn_lr;
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_st));
        chk("cnt_en", 32'(cnt_en), 32'(m_en));
        chk("cnt_clr", 32'(cnt_clr), 32'(m_clr));
        chk("disp", 32'({disp_bcd4, disp_bcd3, disp_bcd2, disp_bcd1}), 32'(to_bcd(m_disp)));
        chk("ovf", 32'(ovf), 32'(m_st == 4));
    endtask

    task automatic check_zero(input string tag);
        chk(tag, 32'({state, cnt_en, cnt_clr, ovf, disp_bcd4, disp_bcd3, disp_bcd2, disp_bcd1}), 32'd0);
    endtask

    task automatic cyc(input bit ss, input bit lr);
        btn_ss = ss;
        btn_lr = lr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    // Asserted just after an edge; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero(tag);
        rst = 1'b0;
    endtask

    task automatic run_until_cnt(input int target);
        int k = 0;
        while (m_cnt != target && k < 400) begin
            cyc(0, 0);
            k++;
        end
        chk("reach_cnt", 32'(m_cnt), 32'(target));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // 1: start and count
        cyc(1, 0);
        chk("start_run", 32'(state), 32'd1);
        idle(40);

        // 2: lap freeze and release
        run_until_cnt(12);
        cyc(0, 1);
        chk("lap_enter", 32'(state), 32'd2);
        idle(14);
        chk("lap_frozen", 32'({disp_bcd4, disp_bcd3, disp_bcd2, disp_bcd1}), 32'h0012);
        cyc(0, 1);
        chk("lap_exit", 32'(state), 32'd1);
        idle(8);

        // 3: held start/stop gives a single pause
        for (int i = 0; i < 20; i++) cyc(1, 0);
        chk("held_pause", 32'(state), 32'd3);
        idle(10);
        cyc(1, 0);
        chk("resume", 32'(state), 32'd1);
        idle(10);

        // 4: clear from pause
        run_until_cnt(37);
        cyc(1, 0);
        chk("pause37", 32'(state), 32'd3);
        idle(3);
        cyc(0, 1);
        chk("clr_pulse", 32'(cnt_clr), 32'd1);
        chk("clr_idle", 32'(state), 32'd0);
        idle(3);
        chk("clr_disp", 32'({disp_bcd4, disp_bcd3, disp_bcd2, disp_bcd1}), 32'h0000);

        // 5: saturation
        ld = 1'b1;
        ld_val = 9990;
        cyc(0, 0);
        ld = 1'b0;
        cyc(1, 0);
        begin
            int k = 0;
            while (m_st != 4 && k < 200) begin
                cyc(0, 0);
                k++;
            end
        end
        chk("ovf_state", 32'(state), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
        idle(100);
        chk("ovf_disp", 32'({disp_bcd4, disp_bcd3, disp_bcd2, disp_bcd1}), 32'h9999);
        cyc(1, 0);
        cyc(0, 0);
        chk("ovf_ss_ign", 32'(state), 32'd4);
        cyc(0, 1);
        chk("ovf_clr", 32'(cnt_clr), 32'd1);
        idle(3);
        chk("ovf_idle", 32'(state), 32'd0);

        // 6: simultaneous buttons, then async reset mid-run
        cyc(1, 0);
        idle(10);
        cyc(1, 1);
        chk("both_pause", 32'(state), 32'd3);
        chk("both_noclr", 32'(cnt_clr), 32'd0);
        idle(2);
        cyc(1, 0);
        idle(7);
        do_reset("rst_midrun");

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            bit ss = ($urandom_range(0, 5) == 0) ? ~btn_ss : btn_ss;
            bit lr = ($urandom_range(0, 9) == 0) ? ~btn_lr : btn_lr;
            if ($urandom_range(0, 199) == 0) begin
                ld = 1'b1;
                ld_val = $urandom_range(9960, 9999);
            end
            cyc(ss, lr);
            ld = 1'b0;
            if ($urandom_range(0, 999) == 0) do_reset("rst_rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
